// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//
// Hazard sequencer for the 5-stage MIPS pipeline. It runs beside the EX/ID
// forwarding logic and decides, on every cycle, whether the front end
// advances, holds, or squashes the instruction it has just fetched.
//
// It handles the hazards that forwarding cannot resolve:
//   LOAD_BR  : a load in EX feeds a branch compare in ID -> 2 stall cycles
//   LOAD_USE : a load in EX feeds a non-branch in ID      -> 1 stall cycle
//   ALU_BR   : an ALU result in EX feeds a branch in ID   -> 1 stall cycle
//
// It also keeps two saturating performance counters, one for stall cycles
// and one for flush cycles.
//
// Parameters:
//   CNT_W        width of the performance counters
//
// Ports:
//   Clk          pipeline clock; all state changes on the rising edge
//   Reset        synchronous, active-high reset
//   RS_ID        rs field of the instruction in ID
//   RT_ID        rt field of the instruction in ID
//   UsesRT_ID    the ID instruction reads rt as a source
//   branch       the ID instruction is a branch (compare is done in ID)
//   BranchTaken  result of the ID branch compare; valid when branch=1
//   MemRead_EX   the EX instruction is a load
//   RegWrite_EX  the EX instruction writes a register
//   RD_EX        destination register of the EX instruction
//   PCWrite      the PC may update
//   IFIDWrite    the IF/ID register may update
//   Bubble_EX    zero the control word entering ID/EX
//   Flush_IF     clear IF/ID (squash the fetched instruction)
//   Stalling     the FSM is in its STALL state (debug)
//   StallCycles  saturating count of stall cycles since reset
//   FlushCount   saturating count of flush cycles since reset
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       RS_ID,
  input  logic [4:0]       RT_ID,
  input  logic             UsesRT_ID,
  input  logic             branch,
  input  logic             BranchTaken,
  input  logic             MemRead_EX,
  input  logic             RegWrite_EX,
  input  logic [4:0]       RD_EX,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             Bubble_EX,
  output logic             Flush_IF,
  output logic             Stalling,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic match_ex;
  logic haz_load_br;
  logic haz_load_use;
  logic haz_alu_br;
  logic stall_now;
  logic flush_now;

  // Increment requests for the counters: bit 0 = stall, bit 1 = flush.
  logic [1:0]            cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_all;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  always_comb begin
    // $0 is hard-wired to zero, so writing it never creates a dependency.
    // rt counts as a source only when the ID instruction actually reads it.
    match_ex = (RD_EX != 5'd0) &&
               ((RD_EX == RS_ID) || (UsesRT_ID && (RD_EX == RT_ID)));

    haz_load_br  = MemRead_EX && branch  && match_ex;
    haz_load_use = MemRead_EX && !branch && match_ex;
    // An ALU result can be forwarded into EX, but not into the compare that
    // is done early in ID. Loads are excluded because LOAD_BR covers them.
    haz_alu_br   = RegWrite_EX && !MemRead_EX && branch && match_ex;
  end

  // ---------------------------------------------------------------------------
  // Per-cycle decision and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_now = 1'b0;
    flush_now = 1'b0;

    if (!Reset) begin
      // In STALL the hazard inputs are ignored and the cycle stalls anyway.
      // In RUN any hazard class stalls the same cycle (Mealy).
      if (state_reg == STALL) begin
        stall_now = 1'b1;
      end else begin
        stall_now = haz_load_br || haz_load_use || haz_alu_br;
      end
      // A branch is acted on only in a cycle that does not stall. The
      // compare result may be stale while its source is still in flight.
      flush_now = !stall_now && branch && BranchTaken;
    end
  end

  always_comb begin
    if (Reset || stall_now) begin
      // Reset forces the same safe front-end hold as a stall.
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      Bubble_EX = 1'b1;
      Flush_IF  = 1'b0;
    end else begin
      PCWrite   = 1'b1;
      IFIDWrite = 1'b1;
      Bubble_EX = 1'b0;
      Flush_IF  = flush_now;
    end
    Stalling = !Reset && (state_reg == STALL);
  end

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      // Only LOAD_BR needs a second stall cycle: the load has to reach WB
      // before its value can feed the compare in ID.
      RUN:     state_next = haz_load_br ? STALL : RUN;
      STALL:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Reset in the middle of a LOAD_BR stall drops the remaining stall cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  assign cnt_inc[0] = stall_now;
  assign cnt_inc[1] = flush_now;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
      logic [CNT_W-1:0] cnt_reg;

      // stall_now and flush_now are already 0 while Reset is high, so the
      // reset branch alone decides what happens in a reset cycle.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign cnt_all[gi] = cnt_reg;
    end
  endgenerate

  assign StallCycles = cnt_all[0];
  assign FlushCount  = cnt_all[1];

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // The expected outputs are packed as {PCWrite, IFIDWrite, Bubble_EX, Flush_IF, Stalling}.
  localparam logic [4:0] NORM    = 5'b11000;
  localparam logic [4:0] NORM_FL = 5'b11010;
  localparam logic [4:0] STL     = 5'b00100;
  localparam logic [4:0] STL_S   = 5'b00101;
  localparam logic [4:0] RST     = 5'b00100;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [4:0]       RS_ID, RT_ID, RD_EX;
  logic             UsesRT_ID, branch, BranchTaken, MemRead_EX, RegWrite_EX;
  logic             PCWrite, IFIDWrite, Bubble_EX, Flush_IF, Stalling;
  logic [CNT_W-1:0] StallCycles, FlushCount;

  hazard_stall_controller #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .RS_ID(RS_ID), .RT_ID(RT_ID),
    .UsesRT_ID(UsesRT_ID), .branch(branch), .BranchTaken(BranchTaken),
    .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX), .RD_EX(RD_EX),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .Bubble_EX(Bubble_EX),
    .Flush_IF(Flush_IF), .Stalling(Stalling),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs, rt;
    logic       urt, br, tk, mr, rw;
    logic [4:0] rd;
    logic [4:0] exp;
  } vec_t;

  typedef struct {
    string            name;
    logic [4:0]       outs;
    logic [CNT_W-1:0] sc, fc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [CNT_W-1:0] m_sc = '0, m_fc = '0;

  function automatic vec_t mk(string name, logic rst, logic [4:0] rs, logic [4:0] rt,
                              logic urt, logic br, logic tk, logic mr, logic rw,
                              logic [4:0] rd, logic [4:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.rs = rs; v.rt = rt; v.urt = urt; v.br = br;
    v.tk = tk; v.mr = mr; v.rw = rw; v.rd = rd; v.exp = exp;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Drives one cycle, pushes the expected result, then pops and compares it
  // on the falling edge. At that point the counters show the edges before
  // this cycle, so the model is advanced only after the expectation is queued.
  task automatic run_vec(vec_t v);
    sb_t e;
    @(posedge Clk);
    #1;
    Reset = v.rst; RS_ID = v.rs; RT_ID = v.rt; UsesRT_ID = v.urt; branch = v.br;
    BranchTaken = v.tk; MemRead_EX = v.mr; RegWrite_EX = v.rw; RD_EX = v.rd;
    e.name = v.name; e.outs = v.exp; e.sc = m_sc; e.fc = m_fc;
    sb_q.push_back(e);
    if (v.rst) begin
      m_sc = '0;
      m_fc = '0;
    end else begin
      if (v.exp[2] && m_sc != CNT_MAX) m_sc = m_sc + 1'b1;
      if (v.exp[1] && m_fc != CNT_MAX) m_fc = m_fc + 1'b1;
    end
    @(negedge Clk);
    e = sb_q.pop_front();
    check({e.name, ".outs"}, {3'b0, PCWrite, IFIDWrite, Bubble_EX, Flush_IF, Stalling},
          {3'b0, e.outs});
    check({e.name, ".StallCycles"}, 8'(StallCycles), 8'(e.sc));
    check({e.name, ".FlushCount"},  8'(FlushCount),  8'(e.fc));
    $display("txn %-12s outs=%b stall_cnt=%0d flush_cnt=%0d", e.name,
             {PCWrite, IFIDWrite, Bubble_EX, Flush_IF, Stalling}, StallCycles, FlushCount);
  endtask

  initial begin
    Reset = 1'b1; RS_ID = '0; RT_ID = '0; UsesRT_ID = 1'b0; branch = 1'b0;
    BranchTaken = 1'b0; MemRead_EX = 1'b0; RegWrite_EX = 1'b0; RD_EX = '0;
    repeat (2) @(posedge Clk);

    //              name          rst rs  rt  urt br tk mr rw rd  expected
    vecs.push_back(mk("reset",      1, 0,  0,  0, 0, 0, 0, 0, 0, RST));
    vecs.push_back(mk("idle",       0, 0,  0,  0, 0, 0, 0, 0, 0, NORM));
    vecs.push_back(mk("lu",         0, 2,  0,  0, 0, 0, 1, 1, 2, STL));
    vecs.push_back(mk("lu_after",   0, 2,  0,  0, 0, 0, 0, 0, 0, NORM));
    vecs.push_back(mk("lb_t",       0, 3,  0,  0, 1, 1, 1, 1, 3, STL));
    vecs.push_back(mk("lb_t1",      0, 3,  0,  0, 1, 1, 1, 1, 3, STL_S));
    vecs.push_back(mk("lb_t2",      0, 3,  0,  0, 1, 1, 0, 0, 0, NORM_FL));
    vecs.push_back(mk("idle2",      0, 0,  0,  0, 0, 0, 0, 0, 0, NORM));
    vecs.push_back(mk("albr_rt",    0, 0,  4,  1, 1, 0, 0, 1, 4, STL));
    vecs.push_back(mk("albr_nort",  0, 0,  4,  0, 1, 0, 0, 1, 4, NORM));
    vecs.push_back(mk("rd_zero",    0, 0,  0,  0, 0, 0, 1, 1, 0, NORM));
    vecs.push_back(mk("br_taken",   0, 1,  0,  0, 1, 1, 0, 1, 5, NORM_FL));
    vecs.push_back(mk("alu_fwd",    0, 6,  0,  0, 0, 0, 0, 1, 6, NORM));
    vecs.push_back(mk("lu_nort",    0, 1,  7,  0, 0, 0, 1, 1, 7, NORM));
    vecs.push_back(mk("lu_rt",      0, 1,  7,  1, 0, 0, 1, 1, 7, STL));
    vecs.push_back(mk("lb2_t",      0, 3,  0,  0, 1, 1, 1, 1, 3, STL));
    vecs.push_back(mk("lb2_ign",    0, 4,  0,  0, 1, 1, 0, 1, 4, STL_S));
    vecs.push_back(mk("lu_rerun",   0, 2,  0,  0, 0, 0, 1, 1, 2, STL));
    vecs.push_back(mk("lb3_t",      0, 3,  0,  0, 1, 1, 1, 1, 3, STL));
    vecs.push_back(mk("rst_mid",    1, 3,  0,  0, 1, 1, 1, 1, 3, RST));
    vecs.push_back(mk("post_rst",   0, 0,  0,  0, 0, 0, 0, 0, 0, NORM));
    vecs.push_back(mk("post_rst2",  0, 1,  0,  0, 1, 1, 0, 0, 0, NORM_FL));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Saturation: hold a load-use hazard, then a stream of taken branches.
    for (int i = 0; i < 20; i++) run_vec(mk("sat_stall", 0, 2, 0, 0, 0, 0, 1, 1, 2, STL));
    for (int i = 0; i < 20; i++) run_vec(mk("sat_flush", 0, 1, 0, 0, 1, 1, 0, 0, 0, NORM_FL));
    run_vec(mk("sat_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    run_vec(mk("sat_rst",  1, 0, 0, 0, 0, 0, 0, 0, 0, RST));
    run_vec(mk("sat_clr",  0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
